// File: rtl/wave_meas.sv
// Loopback measurement receiver: detects rising mid-level crossings with hysteresis,
// then reports the average period and the max/min/peak-to-peak of each NCYC-period window.
module wave_meas #(
  parameter int DW      = 14,
  parameter int MID     = 8192,
  parameter int HYST    = 256,
  parameter int NCYC    = 16,
  parameter int TMO_CYC = 1048576,
  parameter int CW      = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] ADC_out,
  output logic [CW-1:0] period,
  output logic [DW-1:0] vmax,
  output logic [DW-1:0] vmin,
  output logic [DW-1:0] pkpk,
  output logic          meas_valid,
  output logic          no_signal
);

  localparam int NSH = $clog2(NCYC);
  localparam int NW  = NSH + 1;
  localparam int TW  = $clog2(TMO_CYC) + 1;

  localparam logic [DW-1:0] TH_HI    = DW'(MID + HYST);
  localparam logic [DW-1:0] TH_LO    = DW'(MID - HYST);
  localparam logic [NW-1:0] NCR_LAST = NW'(NCYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_MEAS = 2'd2;

  function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] umin(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + CW'(1);
  endfunction

  function automatic logic [TW-1:0] tcnt_sat_inc(input logic [TW-1:0] c);
    return (&c) ? c : c + TW'(1);
  endfunction

  logic [DW-1:0] s_q;
  logic          st_q, st_d;
  logic [1:0]    fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] ncr_q, ncr_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [DW-1:0] mx_q, mx_d, mn_q, mn_d;
  logic [CW-1:0] period_q, period_d;
  logic [DW-1:0] vmax_q, vmax_d, vmin_q, vmin_d, pkpk_q, pkpk_d;
  logic          mv_q, mv_d, ns_q, ns_d;

  logic          rise, tmo;
  logic [DW-1:0] win_max, win_min;

  assign rise    = !st_q && (s_q >= TH_HI);
  assign tmo     = (tcnt_q == TMO_LAST);
  assign win_max = umax(mx_q, s_q);
  assign win_min = umin(mn_q, s_q);

  always_comb begin
    st_d     = st_q;
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    ncr_d    = ncr_q;
    mx_d     = mx_q;
    mn_d     = mn_q;
    period_d = period_q;
    vmax_d   = vmax_q;
    vmin_d   = vmin_q;
    pkpk_d   = pkpk_q;
    mv_d     = 1'b0;
    ns_d     = ns_q;

    if (!en) st_d = 1'b0;
    else if (!st_q && (s_q >= TH_HI)) st_d = 1'b1;
    else if (st_q && (s_q <= TH_LO)) st_d = 1'b0;

    tcnt_d = (rise || !en || fsm_q == S_IDLE) ? '0 : tcnt_sat_inc(tcnt_q);

    if (!en) begin
      fsm_d = S_IDLE;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          cnt_d = '0;
          ncr_d = '0;
          fsm_d = S_ARM;
        end
        S_ARM: begin
          if (rise) begin
            cnt_d = CW'(1);
            ncr_d = '0;
            mx_d  = s_q;
            mn_d  = s_q;
            fsm_d = S_MEAS;
          end else if (tmo) begin
            ns_d = 1'b1;
          end
        end
        S_MEAS: begin
          cnt_d = cnt_sat_inc(cnt_q);
          mx_d  = win_max;
          mn_d  = win_min;
          if (rise) begin
            if (ncr_q == NCR_LAST) begin
              // Completing rise publishes the window and opens the next one with no gap.
              period_d = cnt_q >> NSH;
              vmax_d   = win_max;
              vmin_d   = win_min;
              pkpk_d   = win_max - win_min;
              mv_d     = 1'b1;
              ns_d     = 1'b0;
              cnt_d    = CW'(1);
              ncr_d    = '0;
              mx_d     = s_q;
              mn_d     = s_q;
            end else begin
              ncr_d = ncr_q + NW'(1);
            end
          end else if (tmo) begin
            ns_d  = 1'b1;
            fsm_d = S_ARM;
          end
        end
        default: fsm_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= 1'b0;
      fsm_q    <= S_IDLE;
      cnt_q    <= '0;
      ncr_q    <= '0;
      tcnt_q   <= '0;
      period_q <= '0;
      vmax_q   <= '0;
      vmin_q   <= '0;
      pkpk_q   <= '0;
      mv_q     <= 1'b0;
      ns_q     <= 1'b0;
    end else begin
      st_q     <= st_d;
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      ncr_q    <= ncr_d;
      tcnt_q   <= tcnt_d;
      period_q <= period_d;
      vmax_q   <= vmax_d;
      vmin_q   <= vmin_d;
      pkpk_q   <= pkpk_d;
      mv_q     <= mv_d;
      ns_q     <= ns_d;
    end
  end

  // Sample and window extremes are data only; they are always loaded before use.
  always_ff @(posedge clk) begin
    s_q  <= ADC_out;
    mx_q <= mx_d;
    mn_q <= mn_d;
  end

  assign period     = period_q;
  assign vmax       = vmax_q;
  assign vmin       = vmin_q;
  assign pkpk       = pkpk_q;
  assign meas_valid = mv_q;
  assign no_signal  = ns_q;

endmodule

// File: tb/tb_wave_meas.sv
// Directed bench for wave_meas: square, sawtooth, noise timeout, enable drop,
// mid-window reset and odd-period / single-cycle window configurations.
module tb_wave_meas;

  localparam int TMO = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [13:0] ADC_out = 14'd4000;

  logic [23:0] period, period1;
  logic [13:0] vmax, vmin, pkpk, vmax1, vmin1, pkpk1;
  logic        mv, ns, mv1, ns1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wave_meas #(.NCYC(16), .TMO_CYC(TMO)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ADC_out(ADC_out),
    .period(period), .vmax(vmax), .vmin(vmin), .pkpk(pkpk),
    .meas_valid(mv), .no_signal(ns)
  );

  wave_meas #(.NCYC(1), .TMO_CYC(TMO)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .ADC_out(ADC_out),
    .period(period1), .vmax(vmax1), .vmin(vmin1), .pkpk(pkpk1),
    .meas_valid(mv1), .no_signal(ns1)
  );

  function automatic logic [13:0] sq(input int t, input int per, input int hi);
    return ((t % per) < hi) ? 14'd12000 : 14'd4000;
  endfunction

  function automatic logic [13:0] saw(input int t);
    logic [18:0] ph;
    logic [8:0]  p9;
    ph = 19'(t * 1024);
    p9 = ph[18:10];
    return {p9, p9[8:4]};
  endfunction

  task automatic step(input logic [13:0] v);
    ADC_out = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0;
    ADC_out = 14'd4000;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic preroll();
    en = 1'b1;
    repeat (4) step(14'd4000);
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #3;
    n_chk++; if (period !== 24'd0) begin n_fail++; $display("FAIL rst_period: got %0d expected 0", period); end
    n_chk++; if (vmax !== 14'd0) begin n_fail++; $display("FAIL rst_vmax: got %0d expected 0", vmax); end
    n_chk++; if (vmin !== 14'd0) begin n_fail++; $display("FAIL rst_vmin: got %0d expected 0", vmin); end
    n_chk++; if (pkpk !== 14'd0) begin n_fail++; $display("FAIL rst_pkpk: got %0d expected 0", pkpk); end
    n_chk++; if (mv !== 1'b0) begin n_fail++; $display("FAIL rst_mv: got %0b expected 0", mv); end
    n_chk++; if (ns !== 1'b0) begin n_fail++; $display("FAIL rst_ns: got %0b expected 0", ns); end
    n_chk++; if (period1 !== 24'd0 || mv1 !== 1'b0) begin n_fail++; $display("FAIL rst_dut1: got period %0d mv %0b expected 0/0", period1, mv1); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step((i % 2 == 0) ? 14'd12000 : 14'd4000);
      n_chk++; if (mv !== 1'b0 || period !== 24'd0) begin n_fail++; $display("FAIL rst_post i=%0d: got mv %0b period %0d expected 0/0", i, mv, period); end
    end
  endtask

  task automatic test_square_b2b();
    logic exp_mv;
    do_reset();
    preroll();
    for (int t = 0; t <= 6500; t++) begin
      step(sq(t, 200, 100));
      exp_mv = (t == 3201 || t == 6401);
      n_chk++; if (mv !== exp_mv) begin n_fail++; $display("FAIL sq_mv t=%0d: got %0b expected %0b", t, mv, exp_mv); end
      if (exp_mv) begin
        n_chk++; if (period !== 24'd200) begin n_fail++; $display("FAIL sq_period t=%0d: got %0d expected 200", t, period); end
        n_chk++; if (vmax !== 14'd12000) begin n_fail++; $display("FAIL sq_vmax t=%0d: got %0d expected 12000", t, vmax); end
        n_chk++; if (vmin !== 14'd4000) begin n_fail++; $display("FAIL sq_vmin t=%0d: got %0d expected 4000", t, vmin); end
        n_chk++; if (pkpk !== 14'd8000) begin n_fail++; $display("FAIL sq_pkpk t=%0d: got %0d expected 8000", t, pkpk); end
        n_chk++; if (ns !== 1'b0) begin n_fail++; $display("FAIL sq_ns t=%0d: got %0b expected 0", t, ns); end
      end
    end
  endtask

  task automatic test_sawtooth();
    logic exp_mv;
    do_reset();
    preroll();
    for (int t = 0; t <= 8500; t++) begin
      step(saw(t));
      exp_mv = (t == 8457);
      n_chk++; if (mv !== exp_mv) begin n_fail++; $display("FAIL saw_mv t=%0d: got %0b expected %0b", t, mv, exp_mv); end
      if (exp_mv) begin
        n_chk++; if (period !== 24'd512) begin n_fail++; $display("FAIL saw_period: got %0d expected 512", period); end
        n_chk++; if (vmax !== 14'd16383) begin n_fail++; $display("FAIL saw_vmax: got %0d expected 16383", vmax); end
        n_chk++; if (vmin !== 14'd0) begin n_fail++; $display("FAIL saw_vmin: got %0d expected 0", vmin); end
        n_chk++; if (pkpk !== 14'd16383) begin n_fail++; $display("FAIL saw_pkpk: got %0d expected 16383", pkpk); end
      end
    end
  endtask

  task automatic test_noise_timeout();
    logic exp_mv, exp_ns;
    do_reset();
    preroll();
    // Last rise is sample 400, acted on at step 401; timeout lands TMO edges later.
    for (int t = 0; t < 2600; t++) begin
      step((t < 500) ? sq(t, 200, 100) : 14'(8000 + (t * 37) % 401));
      exp_ns = (t >= 401 + TMO);
      n_chk++; if (mv !== 1'b0) begin n_fail++; $display("FAIL noise_mv t=%0d: got %0b expected 0", t, mv); end
      n_chk++; if (ns !== exp_ns) begin n_fail++; $display("FAIL noise_ns t=%0d: got %0b expected %0b", t, ns, exp_ns); end
    end
    for (int u = 0; u <= 3500; u++) begin
      step(sq(u, 200, 100));
      exp_mv = (u == 3401);
      exp_ns = (u < 3401);
      n_chk++; if (mv !== exp_mv) begin n_fail++; $display("FAIL recov_mv u=%0d: got %0b expected %0b", u, mv, exp_mv); end
      n_chk++; if (ns !== exp_ns) begin n_fail++; $display("FAIL recov_ns u=%0d: got %0b expected %0b", u, ns, exp_ns); end
      if (exp_mv) begin
        n_chk++; if (period !== 24'd200) begin n_fail++; $display("FAIL recov_period: got %0d expected 200", period); end
      end
    end
  endtask

  task automatic test_en_drop();
    logic exp_mv;
    do_reset();
    preroll();
    for (int t = 0; t <= 5500; t++) begin
      if (t == 1050) en = 1'b0;
      if (t == 2150) en = 1'b1;
      step(sq(t, 200, 100));
      exp_mv = (t == 5401);
      n_chk++; if (mv !== exp_mv) begin n_fail++; $display("FAIL en_mv t=%0d: got %0b expected %0b", t, mv, exp_mv); end
      if (exp_mv) begin
        n_chk++; if (period !== 24'd200) begin n_fail++; $display("FAIL en_period: got %0d expected 200", period); end
        n_chk++; if (pkpk !== 14'd8000) begin n_fail++; $display("FAIL en_pkpk: got %0d expected 8000", pkpk); end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic exp_mv;
    do_reset();
    preroll();
    for (int t = 0; t <= 7500; t++) begin
      if (t == 4001) begin
        rst_n = 1'b0;
        #1;
        n_chk++; if (period !== 24'd0) begin n_fail++; $display("FAIL mrst_period: got %0d expected 0", period); end
        n_chk++; if (vmax !== 14'd0) begin n_fail++; $display("FAIL mrst_vmax: got %0d expected 0", vmax); end
        n_chk++; if (vmin !== 14'd0) begin n_fail++; $display("FAIL mrst_vmin: got %0d expected 0", vmin); end
        n_chk++; if (pkpk !== 14'd0) begin n_fail++; $display("FAIL mrst_pkpk: got %0d expected 0", pkpk); end
      end
      if (t == 4003) rst_n = 1'b1;
      step(sq(t, 200, 100));
      exp_mv = (t == 3201 || t == 7401);
      n_chk++; if (mv !== exp_mv) begin n_fail++; $display("FAIL mrst_mv t=%0d: got %0b expected %0b", t, mv, exp_mv); end
      if (exp_mv) begin
        n_chk++; if (period !== 24'd200) begin n_fail++; $display("FAIL mrst_res_period t=%0d: got %0d expected 200", t, period); end
        n_chk++; if (vmin !== 14'd4000) begin n_fail++; $display("FAIL mrst_res_vmin t=%0d: got %0d expected 4000", t, vmin); end
      end
    end
  endtask

  task automatic test_period203();
    logic exp_mv, exp_mv1;
    do_reset();
    preroll();
    for (int t = 0; t <= 3300; t++) begin
      step(sq(t, 203, 101));
      exp_mv  = (t == 3249);
      exp_mv1 = (t >= 204) && ((t - 1) % 203 == 0);
      n_chk++; if (mv !== exp_mv) begin n_fail++; $display("FAIL p203_mv t=%0d: got %0b expected %0b", t, mv, exp_mv); end
      n_chk++; if (mv1 !== exp_mv1) begin n_fail++; $display("FAIL n1_mv t=%0d: got %0b expected %0b", t, mv1, exp_mv1); end
      if (exp_mv) begin
        n_chk++; if (period !== 24'd203) begin n_fail++; $display("FAIL p203_period: got %0d expected 203", period); end
      end
      if (exp_mv1) begin
        n_chk++; if (period1 !== 24'd203) begin n_fail++; $display("FAIL n1_period t=%0d: got %0d expected 203", t, period1); end
        n_chk++; if (vmax1 !== 14'd12000 || vmin1 !== 14'd4000) begin n_fail++; $display("FAIL n1_minmax t=%0d: got %0d/%0d expected 12000/4000", t, vmax1, vmin1); end
        n_chk++; if (pkpk1 !== 14'd8000) begin n_fail++; $display("FAIL n1_pkpk t=%0d: got %0d expected 8000", t, pkpk1); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_square_b2b();
    test_sawtooth();
    test_noise_timeout();
    test_en_drop();
    test_mid_reset();
    test_period203();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
